// File: rtl/mem_ctrl_core_pkg.sv
// mem_ctrl_core_pkg: shared enums, widths and FSM state for the memory controller slice
package controlpack;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 16;
   typedef enum logic [1:0] {ADDR_NOP, ADDR_LOAD_LO, ADDR_LOAD_HI, ADDR_INC} addr_reg_op_e;
   typedef enum logic [1:0] {ADDR_SEL_PC, ADDR_SEL_MAR} addr_sel_e;
   typedef enum logic [1:0] {MEM_NOP, MEM_READ, MEM_WRITE} mem_op_e;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;
endpackage

// File: rtl/mem_ctrl_core_if.sv
// mem_ctrl_core_if: external serial memory engine bus (controller = master, engine = slave)
interface mem_ctrl_core_if #(parameter int DW = 8);
   logic [24:0]   addr_out;
   logic [DW-1:0] data_out;
   logic [DW-1:0] data_in;
   logic          start_read;
   logic          start_write;
   logic          stall_txn;
   logic          stop_txn;
   logic          data_req;
   logic          data_ready;
   modport master (output addr_out, data_out, start_read, start_write, stall_txn, stop_txn,
                   input data_in, data_req, data_ready);
   modport slave  (input addr_out, data_out, start_read, start_write, stall_txn, stop_txn,
                   output data_in, data_req, data_ready);
endinterface

// File: rtl/mem_addr_reg.sv
// mem_addr_reg: one address register with byte loads and wrapping increment
module mem_addr_reg
   import controlpack::*;
#(parameter int W = ADDR_W)
(
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  addr_reg_op_e op,
   input  logic [W/2-1:0] din,
   output logic [W-1:0] q
);
   // apply the requested operation when enabled; increment wraps naturally
   always_ff @(posedge clock)
      if (reset) q <= '0;
      else if (en) q <= op == ADDR_LOAD_LO ? {q[W-1:W/2], din} :
                       op == ADDR_LOAD_HI ? {din, q[W/2-1:0]} :
                       op == ADDR_INC     ? q + {{(W-1){1'b0}}, 1'b1} : q;
endmodule

// File: rtl/mem_ctrl_core.sv
// mem_ctrl_core: PC/MAR address registers and single-byte read/write sequencer; MEM_AUTO_INC_EN enables post-transaction increment
module mem_ctrl_core
   import controlpack::*;
#(
   parameter int DATA_BUS_WIDTH = DATA_W,
   parameter int ADDRESS_WIDTH  = ADDR_W
)
(
   input  logic                      clock,
   input  logic                      reset,
   input  addr_reg_op_e              addr_reg_op,
   input  addr_sel_e                 addr_sel,
   input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
   input  mem_op_e                   op,
   output logic [DATA_BUS_WIDTH-1:0] bus_data_out,
   output logic                      op_done_out,
   mem_ctrl_core_if.master           mem
);
   state_e                   state;
   addr_sel_e                sel_q;
   logic [ADDRESS_WIDTH-1:0] pc, mar;
   logic                     idle, auto_inc;
   addr_sel_e                cur_sel;
   addr_reg_op_e             reg_op;
   assign idle    = state == IDLE;
   assign cur_sel = idle ? addr_sel : sel_q;
`ifdef MEM_AUTO_INC_EN
   assign auto_inc = state == DONE;
`else
   assign auto_inc = 1'b0;
`endif
   // address ops only act in IDLE; the DONE-state increment targets the latched register
   assign reg_op = auto_inc ? ADDR_INC : idle ? addr_reg_op : ADDR_NOP;
   mem_addr_reg #(.W(ADDRESS_WIDTH)) u_pc  (.clock(clock), .reset(reset), .en(cur_sel == ADDR_SEL_PC),
                                            .op(reg_op), .din(bus_data_in), .q(pc));
   mem_addr_reg #(.W(ADDRESS_WIDTH)) u_mar (.clock(clock), .reset(reset), .en(cur_sel == ADDR_SEL_MAR),
                                            .op(reg_op), .din(bus_data_in), .q(mar));
   assign mem.addr_out    = {cur_sel == ADDR_SEL_MAR, {(24-ADDRESS_WIDTH){1'b0}},
                             cur_sel == ADDR_SEL_MAR ? mar : pc};
   // strobes are gated by reset so an aborted transaction emits nothing
   assign mem.start_read  = !reset && idle && op == MEM_READ;
   assign mem.start_write = !reset && idle && op == MEM_WRITE;
   assign mem.stop_txn    = !reset && ((state == RD_WAIT && mem.data_ready) || (state == WR_WAIT && mem.data_req));
   assign mem.stall_txn   = 1'b0;
   assign op_done_out     = !reset && state == DONE;
   // transaction sequencer with registered read byte and write byte
   always_ff @(posedge clock)
      if (reset) begin
         state        <= IDLE;
         sel_q        <= ADDR_SEL_PC;
         bus_data_out <= '0;
         mem.data_out <= '0;
      end else
         case (state)
            IDLE:
               if (op == MEM_READ) begin
                  sel_q <= addr_sel;
                  state <= RD_WAIT;
               end else if (op == MEM_WRITE) begin
                  sel_q        <= addr_sel;
                  mem.data_out <= bus_data_in;
                  state        <= WR_WAIT;
               end
            RD_WAIT:
               if (mem.data_ready) begin
                  bus_data_out <= mem.data_in;
                  state        <= DONE;
               end
            WR_WAIT: if (mem.data_req) state <= DONE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_mem_ctrl_core.sv
// tb_mem_ctrl_core: scoreboard bench with randomized address ops and transactions
module tb_mem_ctrl_core;
   import controlpack::*;
   typedef struct {logic [24:0] addr; logic wr; logic [7:0] data;} exp_t;
   logic         clock = 0, reset = 1;
   addr_reg_op_e addr_reg_op = ADDR_NOP;
   addr_sel_e    addr_sel = ADDR_SEL_PC;
   logic [7:0]   bus_data_in = 0, bus_data_out;
   mem_op_e      op = MEM_NOP;
   logic         op_done_out;
   int           n_cmp = 0, n_fail = 0;
   exp_t         q_start[$], q_stop[$];
   logic [7:0]   q_done[$];
   logic [15:0]  mdl[2];
   logic [7:0]   mdl_rd;
   mem_ctrl_core_if #(.DW(8)) m ();
   mem_ctrl_core dut (.clock(clock), .reset(reset), .addr_reg_op(addr_reg_op), .addr_sel(addr_sel),
                      .bus_data_in(bus_data_in), .op(op), .bus_data_out(bus_data_out),
                      .op_done_out(op_done_out), .mem(m));
   always #5 clock = ~clock;
   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [24:0] ea(int s);
      return {s[0], 8'h00, mdl[s]};
   endfunction
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic mdl_op(int s, addr_reg_op_e o, logic [7:0] d);
      if (o == ADDR_LOAD_LO) mdl[s][7:0] = d;
      else if (o == ADDR_LOAD_HI) mdl[s][15:8] = d;
      else if (o == ADDR_INC) mdl[s] = mdl[s] + 16'd1;
   endtask
   task automatic mdl_auto(int s);
`ifdef MEM_AUTO_INC_EN
      mdl[s] = mdl[s] + 16'd1;
`else
      mdl[s] = mdl[s];
`endif
   endtask
   // monitor: every strobe from the DUT must match the next queued expectation
   always @(negedge clock) begin
      exp_t e;
      cmp("stall_txn", 32'(m.stall_txn), 0);
      if (m.start_read || m.start_write) begin
         if (q_start.size() == 0) cmp("start_unexpected", 1, 0);
         else begin
            e = q_start.pop_front();
            cmp("start_kind", {m.start_read, m.start_write}, {!e.wr, e.wr});
            cmp("start_addr", 32'(m.addr_out), 32'(e.addr));
         end
      end
      if (m.stop_txn) begin
         if (q_stop.size() == 0) cmp("stop_unexpected", 1, 0);
         else begin
            e = q_stop.pop_front();
            cmp("stop_addr", 32'(m.addr_out), 32'(e.addr));
            if (e.wr) cmp("write_data", 32'(m.data_out), 32'(e.data));
         end
      end
      if (op_done_out) begin
         if (q_done.size() == 0) cmp("done_unexpected", 1, 0);
         else cmp("done_rdata", 32'(bus_data_out), 32'(q_done.pop_front()));
      end
   end
   task automatic chk_addr(int s);
      addr_sel = addr_sel_e'(s);
      #1;
      cmp("addr_out", 32'(m.addr_out), 32'(ea(s)));
   endtask
   task automatic addr_op(int s, addr_reg_op_e o, logic [7:0] d);
      addr_sel = addr_sel_e'(s); addr_reg_op = o; bus_data_in = d;
      m.data_ready = 1'($urandom); m.data_req = 1'($urandom);
      tick();
      mdl_op(s, o, d);
      addr_reg_op = ADDR_NOP; m.data_ready = 0; m.data_req = 0;
   endtask
   task automatic busy_noise(bit rd, int w);
      for (int i = 0; i < w; i++) begin
         op = mem_op_e'($urandom_range(0, 2));
         addr_reg_op = addr_reg_op_e'($urandom_range(0, 3));
         addr_sel = addr_sel_e'($urandom_range(0, 1));
         bus_data_in = 8'($urandom);
         m.data_in = 8'($urandom);
         if (rd) m.data_req = 1'($urandom); else m.data_ready = 1'($urandom);
         tick();
      end
      op = MEM_NOP; addr_reg_op = ADDR_NOP; m.data_req = 0; m.data_ready = 0;
   endtask
   task automatic do_read(int s, addr_reg_op_e ao, logic [7:0] ad, logic [7:0] d, int w);
      addr_sel = addr_sel_e'(s); op = MEM_READ; addr_reg_op = ao; bus_data_in = ad;
      q_start.push_back('{ea(s), 1'b0, 8'h00});
      mdl_op(s, ao, ad);
      tick();
      busy_noise(1, w);
      m.data_ready = 1; m.data_in = d;
      q_stop.push_back('{ea(s), 1'b0, 8'h00});
      tick();
      m.data_ready = 0;
      q_done.push_back(d);
      mdl_rd = d;
      tick();
      mdl_auto(s);
   endtask
   task automatic do_write(int s, logic [7:0] d, int w);
      addr_sel = addr_sel_e'(s); op = MEM_WRITE; bus_data_in = d;
      q_start.push_back('{ea(s), 1'b1, d});
      tick();
      busy_noise(0, w);
      m.data_req = 1;
      q_stop.push_back('{ea(s), 1'b1, d});
      tick();
      m.data_req = 0;
      q_done.push_back(mdl_rd);
      tick();
      mdl_auto(s);
   endtask
   initial begin
      m.data_in = 0; m.data_req = 0; m.data_ready = 0;
      mdl[0] = 0; mdl[1] = 0; mdl_rd = 0;
      tick(); tick();
      cmp("rst_addr", 32'(m.addr_out), 0);
      cmp("rst_rdata", 32'(bus_data_out), 0);
      cmp("rst_strobes", {m.start_read, m.start_write, m.stop_txn, op_done_out}, 0);
      reset = 0;
      addr_op(1, ADDR_LOAD_LO, 8'h34);
      addr_op(1, ADDR_LOAD_HI, 8'h12);
      chk_addr(1);
      cmp("mar_1234", 32'(m.addr_out), 32'h1001234);
      chk_addr(0);
      addr_op(0, ADDR_LOAD_LO, 8'hFF);
      addr_op(0, ADDR_LOAD_HI, 8'hFF);
      addr_op(0, ADDR_INC, 8'h00);
      chk_addr(0);
      cmp("pc_wrap", 32'(m.addr_out), 0);
      addr_op(0, ADDR_LOAD_LO, 8'h77);
      addr_op(0, ADDR_NOP, 8'h99);
      chk_addr(0);
      addr_op(1, ADDR_LOAD_LO, 8'h42);
      addr_op(1, ADDR_LOAD_HI, 8'h00);
      do_read(1, ADDR_NOP, 8'h00, 8'hA5, 2);
      chk_addr(1);
      cmp("rd_a5", 32'(bus_data_out), 32'hA5);
      do_write(1, 8'h5A, 1);
      chk_addr(1);
      do_read(0, ADDR_LOAD_LO, 8'hC3, 8'h3C, 0);
      chk_addr(0);
      addr_sel = ADDR_SEL_MAR; op = MEM_READ;
      q_start.push_back('{ea(1), 1'b0, 8'h00});
      tick();
      op = MEM_NOP; reset = 1; m.data_ready = 1; m.data_in = 8'hFF;
      tick();
      reset = 0; m.data_ready = 0;
      mdl[0] = 0; mdl[1] = 0; mdl_rd = 0;
      chk_addr(1);
      chk_addr(0);
      cmp("rst_mid_rdata", 32'(bus_data_out), 0);
      addr_op(0, ADDR_LOAD_LO, 8'h10);
      do_read(0, ADDR_NOP, 8'h00, 8'h66, 1);
      chk_addr(0);
      for (int i = 0; i < 60; i++) begin
         int s = $urandom_range(0, 1);
         case ($urandom_range(0, 2))
            0: addr_op(s, addr_reg_op_e'($urandom_range(0, 3)), 8'($urandom));
            1: do_read(s, addr_reg_op_e'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
            default: do_write(s, 8'($urandom), $urandom_range(0, 3));
         endcase
         chk_addr($urandom_range(0, 1));
      end
      tick(); tick();
      cmp("start_left", q_start.size(), 0);
      cmp("stop_left", q_stop.size(), 0);
      cmp("done_left", q_done.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
